// File: rtl/acc_buf_pkg.sv
// Shared line-buffer definitions used by the ifmap writer and the data_router read side.
package acc_buf_pkg;

    localparam int unsigned ADDR_COLW = 28;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_FILL  = 2'd1,
        WR_FULL  = 2'd2,
        WR_DRAIN = 2'd3
    } wr_state_e;

    // Bank word address as seen by both the writer and the router.
    typedef struct packed {
        logic [1:0]           bank;
        logic [1:0]           row;
        logic [ADDR_COLW-1:0] col;
    } bank_addr_t;

    // Next bank index with wrap at nbank.
    function automatic logic [1:0] bank_inc(input logic [1:0] b, input int unsigned nbank);
        return (b == 2'(nbank - 1)) ? 2'd0 : b + 2'd1;
    endfunction

endpackage

// File: rtl/bank_credit.sv
// Bank occupancy credits: rows become resident on row completion and are
// released by the router's block-end pulse. Underflow clamps to zero and
// raises a sticky error.
module bank_credit #(
    parameter int NBANK  = 4,
    parameter int KSIZE  = 3,
    parameter int STRIDE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       active,
    input  logic       row_done,
    input  logic       blkend,
    input  logic       drain,
    output logic [3:0] occ,
    output logic [3:0] occ_next,
    output logic       err,
    output logic       blk_ready
);

    logic [3:0] sum;
    logic       underflow;

    // Next occupancy: add completed row, subtract released rows, clamp at zero.
    always_comb begin
        sum       = occ + {3'd0, row_done};
        occ_next  = occ;
        underflow = 1'b0;
        if (clear) begin
            occ_next = '0;
        end else if (active) begin
            if (blkend) begin
                if (sum < 4'(STRIDE)) begin
                    occ_next  = '0;
                    underflow = 1'b1;
                end else begin
                    occ_next = sum - 4'(STRIDE);
                end
            end else begin
                occ_next = sum;
            end
        end
    end

    // Register occupancy, sticky error and window-ready indication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ       <= '0;
            err       <= 1'b0;
            blk_ready <= 1'b0;
        end else begin
            occ       <= occ_next;
            err       <= clear ? 1'b0 : (err | underflow);
            blk_ready <= (occ_next >= 4'(KSIZE)) || (drain && (occ_next != 4'd0));
        end
    end

endmodule

// File: rtl/ifmap_buf_writer.sv
// Write-side front end of the input feature-map line buffer: accepts DMA
// lines and writes them row/channel/column ordered into rotating banks.
module ifmap_buf_writer
    import acc_buf_pkg::*;
#(
    parameter int DW     = 32,
    parameter int BUFW   = 32,
    parameter int NBANK  = 4,
    parameter int CH     = 4,
    parameter int KSIZE  = 3,
    parameter int STRIDE = 1,
    parameter int COLW   = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [COLW-1:0]      cfg_cols,
    input  logic [15:0]          cfg_rows,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW*BUFW-1:0]   s_data,
    output logic                 wr_en,
    output logic [1:0]           wr_bank,
    output logic [1:0]           wr_row,
    output logic [COLW-1:0]      wr_col,
    output logic [DW*BUFW-1:0]   wr_data,
    input  logic                 blkend,
    output logic                 blk_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    wr_state_e       state;
    logic [COLW-1:0] cols_q;
    logic [15:0]     rows_q;
    logic [COLW-1:0] col;
    logic [1:0]      ch;
    logic [1:0]      bank;
    logic [15:0]     row_cnt;

    logic       hs;
    logic       col_last;
    logic       ch_last;
    logic       row_done;
    logic       last_row;
    logic       clear;
    logic       drain;
    logic [3:0] occ;
    logic [3:0] occ_next;

    assign s_ready  = (state == WR_FILL) && (occ < 4'(NBANK));
    assign busy     = (state != WR_IDLE);
    assign hs       = s_valid && s_ready;
    assign col_last = (col == cols_q - COLW'(1));
    assign ch_last  = (ch == 2'(CH - 1));
    assign row_done = hs && col_last && ch_last;
    assign last_row = ((row_cnt + 16'd1) == rows_q);
    assign clear    = (state == WR_IDLE) && start;
    // The tail-availability term must already hold in the cycle the last row lands.
    assign drain    = (state == WR_DRAIN) || (row_done && last_row);

    bank_credit #(
        .NBANK  (NBANK),
        .KSIZE  (KSIZE),
        .STRIDE (STRIDE)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .active    (busy),
        .row_done  (row_done),
        .blkend    (blkend),
        .drain     (drain),
        .occ       (occ),
        .occ_next  (occ_next),
        .err       (err),
        .blk_ready (blk_ready)
    );

    // Frame FSM, address counters and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WR_IDLE;
            cols_q  <= '0;
            rows_q  <= '0;
            col     <= '0;
            ch      <= '0;
            bank    <= '0;
            row_cnt <= '0;
            wr_en   <= 1'b0;
            wr_bank <= '0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            wr_en <= hs;
            done  <= 1'b0;
            if (hs) begin
                wr_bank <= bank;
                wr_row  <= ch;
                wr_col  <= col;
                wr_data <= s_data;
            end
            case (state)
                WR_IDLE: begin
                    if (start) begin
                        cols_q  <= cfg_cols;
                        rows_q  <= cfg_rows;
                        col     <= '0;
                        ch      <= '0;
                        bank    <= '0;
                        row_cnt <= '0;
                        state   <= WR_FILL;
                    end
                end
                WR_FILL: begin
                    if (hs) begin
                        if (col_last) begin
                            col <= '0;
                            if (ch_last) begin
                                ch      <= '0;
                                bank    <= bank_inc(bank, NBANK);
                                row_cnt <= row_cnt + 16'd1;
                            end else begin
                                ch <= ch + 2'd1;
                            end
                        end else begin
                            col <= col + COLW'(1);
                        end
                    end
                    if (row_done) begin
                        if (last_row) begin
                            state <= WR_DRAIN;
                            done  <= 1'b1;
                        end else if (occ_next >= 4'(NBANK)) begin
                            state <= WR_FULL;
                        end
                    end
                end
                WR_FULL: begin
                    if (occ_next < 4'(NBANK)) begin
                        state <= WR_FILL;
                    end
                end
                WR_DRAIN: begin
                    if (occ_next == 4'd0) begin
                        state <= WR_IDLE;
                    end
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifmap_buf_writer.sv
// Scoreboard bench for ifmap_buf_writer: expected writes are queued at each
// handshake and compared when the registered write port fires.
module tb_ifmap_buf_writer;

    localparam int DW   = 32;
    localparam int BUFW = 32;
    localparam int COLW = 28;
    localparam int LW   = DW * BUFW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [COLW-1:0] cfg_cols = '0;
    logic [15:0]     cfg_rows = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [LW-1:0]   s_data = '0;
    logic            wr_en;
    logic [1:0]      wr_bank;
    logic [1:0]      wr_row;
    logic [COLW-1:0] wr_col;
    logic [LW-1:0]   wr_data;
    logic            blkend = 1'b0;
    logic            blk_ready;
    logic            busy;
    logic            done;
    logic            err;

    typedef struct {
        logic [1:0]      bank;
        logic [1:0]      row;
        logic [COLW-1:0] col;
        logic [LW-1:0]   data;
        logic            done;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    ifmap_buf_writer #(
        .DW     (DW),
        .BUFW   (BUFW),
        .NBANK  (4),
        .CH     (4),
        .KSIZE  (3),
        .STRIDE (1),
        .COLW   (COLW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_cols  (cfg_cols),
        .cfg_rows  (cfg_rows),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .blkend    (blkend),
        .blk_ready (blk_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 64'(wr_en), 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_bank", 64'(wr_bank), 64'(e.bank));
                chk("wr_row",  64'(wr_row),  64'(e.row));
                chk("wr_col",  64'(wr_col),  64'(e.col));
                chk("wr_data", 64'(wr_data === e.data), 64'd1);
                chk("wr_done", 64'(done),    64'(e.done));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int cols, input int rows);
        start    = 1'b1;
        cfg_cols = COLW'(cols);
        cfg_rows = 16'(rows);
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        exp_q.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_blkend();
        blkend = 1'b1;
        step();
        blkend = 1'b0;
    endtask

    // Offer one line; queue its expected write at the handshake edge.
    task automatic send_line(input int bank, input int ch, input int col,
                             input bit last, input bit be);
        logic [LW-1:0] d;
        bit            got;
        wr_t           e;
        for (int i = 0; i < BUFW; i++) d[i*DW +: DW] = $urandom;
        s_valid = 1'b1;
        s_data  = d;
        got     = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (s_ready) begin
                blkend = be;
                e.bank = 2'(bank);
                e.row  = 2'(ch);
                e.col  = COLW'(col);
                e.data = d;
                e.done = last;
                exp_q.push_back(e);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
            blkend = 1'b0;
        end
        s_valid = 1'b0;
        if (!got) chk("hs_timeout", 64'(s_ready), 64'd1);
    endtask

    task automatic send_row(input int bank, input int cols, input bit last_row,
                            input bit be_last, input bit gap);
        for (int ch = 0; ch < 4; ch++) begin
            for (int col = 0; col < cols; col++) begin
                bit fin;
                fin = (ch == 3) && (col == cols - 1);
                send_line(bank, ch, col, last_row && fin, be_last && fin);
                if (gap) step();
            end
        end
    endtask

    task automatic wait_empty();
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en",     64'(wr_en),     64'd0);
        chk("rst_s_ready",   64'(s_ready),   64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_err",       64'(err),       64'd0);
        chk("rst_blk_ready", 64'(blk_ready), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Three rows of 2 columns into banks 0..2, continuous stream
        do_start(2, 3);
        chk("t1_busy", 64'(busy), 64'd1);
        send_row(0, 2, 1'b0, 1'b0, 1'b0);
        send_row(1, 2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_blk_ready_occ2", 64'(blk_ready), 64'd0);
        step();
        send_row(2, 2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_blk_ready", 64'(blk_ready), 64'd1);
        chk("t1_sready_drain", 64'(s_ready), 64'd0);
        @(negedge clk);
        chk("t1_done_1cyc", 64'(done), 64'd0);
        chk("t1_busy_drain", 64'(busy), 64'd1);
        step();

        // Fill all four banks, then a credit reopens the stream into bank 0
        do_reset();
        do_start(1, 6);
        for (int r = 0; r < 4; r++) send_row(r, 1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_full_sready", 64'(s_ready), 64'd0);
        chk("t2_full_blk_ready", 64'(blk_ready), 64'd1);
        pulse_blkend();
        @(negedge clk);
        chk("t2_credit_sready", 64'(s_ready), 64'd1);
        step();
        send_row(0, 1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_refull_sready", 64'(s_ready), 64'd0);
        step();

        // Row completion and blkend together at occ=3 leaves occ at 3
        do_reset();
        do_start(1, 6);
        for (int r = 0; r < 3; r++) send_row(r, 1, 1'b0, 1'b0, 1'b0);
        send_row(3, 1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t3_err", 64'(err), 64'd0);
        chk("t3_sready", 64'(s_ready), 64'd1);
        chk("t3_blk_ready", 64'(blk_ready), 64'd1);
        step();
        send_row(0, 1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_occ4_sready", 64'(s_ready), 64'd0);
        step();

        // Underflow in FILL sets a sticky err; frame drains to IDLE
        do_reset();
        do_start(1, 1);
        pulse_blkend();
        @(negedge clk);
        chk("t4_err_set", 64'(err), 64'd1);
        chk("t4_blk_ready0", 64'(blk_ready), 64'd0);
        step();
        send_row(0, 1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_drain_blk_ready", 64'(blk_ready), 64'd1);
        chk("t4_err_held", 64'(err), 64'd1);
        pulse_blkend();
        @(negedge clk);
        chk("t4_idle_busy", 64'(busy), 64'd0);
        chk("t4_idle_blk_ready", 64'(blk_ready), 64'd0);
        chk("t4_err_sticky", 64'(err), 64'd1);
        step();
        do_start(4, 1);
        @(negedge clk);
        chk("t4_err_cleared", 64'(err), 64'd0);
        step();

        // Gapped input: columns advance only on handshakes
        send_row(0, 4, 1'b1, 1'b0, 1'b1);
        wait_empty();
        step();

        // Reset while a row is being written, then restart cleanly
        do_reset();
        do_start(2, 3);
        send_line(0, 0, 0, 1'b0, 1'b0);
        send_line(0, 0, 1, 1'b0, 1'b0);
        send_line(0, 1, 0, 1'b0, 1'b0);
        chk("t5_pre_rst_wr_en", 64'(wr_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_wr_en",   64'(wr_en),   64'd0);
        chk("t5_rst_wr_row",  64'(wr_row),  64'd0);
        chk("t5_rst_busy",    64'(busy),    64'd0);
        chk("t5_rst_s_ready", 64'(s_ready), 64'd0);
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
        do_start(1, 1);
        send_row(0, 1, 1'b1, 1'b0, 1'b0);

        wait_empty();
        chk("leftover", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
